hs_cdc_rx: RTL and testbench

- Receive endpoint of the 4-phase req/ack clock-domain-crossing handshake. Lives entirely in the rclk domain.
- The send side drives `req` and a data word held stable while `req` is high. This block synchronizes `req`, captures the word and presents it downstream with valid/ready. It returns `ack` only after the downstream consumer has accepted the word.
- Instantiated once per crossing, next to the sclk-domain sender.

---
 rtl/hs_cdc_pkg.sv | 18 +
 rtl/hs_sync_bit.sv | 21 ++
 rtl/hs_cdc_rx.sv | 112 +++++++++++
 tb/tb_hs_cdc_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hs_cdc_pkg.sv
// Shared definitions for the req/ack CDC handshake (sender and receiver sides).
package hs_cdc_pkg;

  localparam int unsigned HS_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    HOLD     = 2'd2,
    ACK      = 2'd3
  } hs_state_e;

  // Even-parity error over a word plus its parity bit.
  function automatic logic hs_par_bad(input logic [31:0] word, input logic par);
    return (^word) ^ par;
  endfunction

endpackage

// File: rtl/hs_sync_bit.sv
// N-flop single-bit synchronizer with a configurable reset value.
module hs_sync_bit #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= {STAGES{RST_VAL}};
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/hs_cdc_rx.sv
// Receive endpoint of a 4-phase req/ack CDC handshake, presenting words via valid/ready.
// Optional even-parity checking is built when HS_RX_PARITY_EN is defined.
module hs_cdc_rx
  import hs_cdc_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = HS_SYNC_STAGES,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             rclk,
  input  logic             reset_n,
  input  logic             req,
  input  logic [WIDTH-1:0] data_in,
`ifdef HS_RX_PARITY_EN
  input  logic             data_par,
  output logic             par_err,
`endif
  output logic             ack,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] rx_count
);

  hs_state_e        state_q, state_d;
  logic             req_s;
  logic             ack_d;
  logic             valid_d;
  logic [WIDTH-1:0] data_d;
  logic [CNT_W-1:0] cnt_d;
  logic             capture_c;

  // Reset value 1 makes a req held high across reset look like an old request.
  hs_sync_bit #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_req_sync (
    .clk  (rclk),
    .rst_n(reset_n),
    .d    (req),
    .q    (req_s)
  );

  always_ff @(posedge rclk or negedge reset_n) begin
    if (!reset_n) state_q <= WAIT_LOW;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ack_d     = ack;
    valid_d   = out_valid;
    data_d    = data_out;
    cnt_d     = rx_count;
    capture_c = 1'b0;
    case (state_q)
      WAIT_LOW: begin
        ack_d = 1'b0;
        if (!req_s) state_d = IDLE;
      end
      IDLE: begin
        if (req_s) begin
          capture_c = 1'b1;
          data_d    = data_in;
          valid_d   = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = rx_count + CNT_W'(1);
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  always_ff @(posedge rclk or negedge reset_n) begin
    if (!reset_n) begin
      ack       <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      rx_count  <= '0;
    end else begin
      ack       <= ack_d;
      out_valid <= valid_d;
      data_out  <= data_d;
      rx_count  <= cnt_d;
    end
  end

`ifdef HS_RX_PARITY_EN
  // Sticky: only reset clears a recorded parity error.
  always_ff @(posedge rclk or negedge reset_n) begin
    if (!reset_n)                                        par_err <= 1'b0;
    else if (capture_c && hs_par_bad(32'(data_in), data_par)) par_err <= 1'b1;
  end
`else
  logic unused_capture;
  assign unused_capture = capture_c;
`endif

endmodule

// File: tb/tb_hs_cdc_rx.sv
// Self-checking bench for hs_cdc_rx: directed handshake cases plus a randomized scoreboard run.
module tb_hs_cdc_rx;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             rclk      = 1'b0;
  logic             reset_n   = 1'b0;
  logic             req       = 1'b0;
  logic [WIDTH-1:0] data_in   = '0;
  logic             out_ready = 1'b0;
  logic             ack;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic [CNT_W-1:0] rx_count;
`ifdef HS_RX_PARITY_EN
  logic             data_par  = 1'b0;
  logic             par_err;
`endif

  hs_cdc_rx #(.WIDTH(WIDTH), .SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
    .rclk     (rclk),
    .reset_n  (reset_n),
    .req      (req),
    .data_in  (data_in),
`ifdef HS_RX_PARITY_EN
    .data_par (data_par),
    .par_err  (par_err),
`endif
    .ack      (ack),
    .data_out (data_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rx_count (rx_count)
  );

  always #5 rclk = ~rclk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic drive_word(input logic [WIDTH-1:0] w, input bit bad_par);
    data_in = w;
`ifdef HS_RX_PARITY_EN
    data_par = (^w) ^ bad_par;
`else
    if (bad_par) data_in = w;
`endif
  endtask

  // Bounded wait on ack (on_ack=1) or out_valid; timeout is a failed comparison.
  task automatic wait_sig(input string tag, input bit on_ack, input logic val, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((on_ack ? ack : out_valid) === val) return;
      @(negedge rclk);
    end
    check(tag, 32'(on_ack ? ack : out_valid), 32'(val));
  endtask

  // Complete handshake with a ready consumer, checking the delivered word.
  task automatic do_word(input string tag, input logic [WIDTH-1:0] w, input bit bad_par);
    drive_word(w, bad_par);
    req = 1'b1;
    wait_sig({tag, "_valid"}, 1'b0, 1'b1, 20);
    check({tag, "_data"}, 32'(data_out), 32'(w));
    wait_sig({tag, "_ack1"}, 1'b1, 1'b1, 20);
    req = 1'b0;
    wait_sig({tag, "_ack0"}, 1'b1, 1'b0, 20);
  endtask

  task automatic do_reset();
    req = 1'b0;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(4);
  endtask

  logic [WIDTH-1:0] sb_q[$];
  int               delivered;
  int               exp_cnt;

  initial begin
    // Reset state
    out_ready = 1'b1;
    tick(2);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_count", 32'(rx_count), 32'd0);
    reset_n = 1'b1;
    tick(4);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_ack", 32'(ack), 32'd0);

    // Latency: first sample at edge 0, out_valid after edge 2, ack after edge 3
    drive_word(4'hF, 1'b0);
    req = 1'b1;
    tick(1); check("lat_e0_valid", 32'(out_valid), 32'd0);
    tick(1); check("lat_e1_valid", 32'(out_valid), 32'd0);
    tick(1); check("lat_e2_valid", 32'(out_valid), 32'd1);
    check("lat_e2_data", 32'(data_out), 32'hF);
    check("lat_e2_ack", 32'(ack), 32'd0);
    tick(1); check("lat_e3_ack", 32'(ack), 32'd1);
    check("lat_e3_valid", 32'(out_valid), 32'd0);
    check("lat_e3_count", 32'(rx_count), 32'd1);
    req = 1'b0;
    tick(1); check("drop_e0_ack", 32'(ack), 32'd1);
    tick(1); check("drop_e1_ack", 32'(ack), 32'd1);
    tick(1); check("drop_e2_ack", 32'(ack), 32'd0);
    check("drop_data_hold", 32'(data_out), 32'hF);

    // Back-pressure: word stays presented while out_ready is low
    tick(2);
    out_ready = 1'b0;
    drive_word(4'b1001, 1'b0);
    req = 1'b1;
    wait_sig("stall_valid", 1'b0, 1'b1, 10);
    for (int i = 0; i < 10; i++) begin
      check("stall_valid_hold", 32'(out_valid), 32'd1);
      check("stall_data", 32'(data_out), 32'h9);
      check("stall_ack", 32'(ack), 32'd0);
      tick(1);
    end
    out_ready = 1'b1;
    tick(1);
    check("stall_accept_valid", 32'(out_valid), 32'd0);
    check("stall_accept_ack", 32'(ack), 32'd1);
    check("stall_count", 32'(rx_count), 32'd2);
    req = 1'b0;
    wait_sig("stall_ack0", 1'b1, 1'b0, 10);

    // Reset mid-transfer with req held high through it
    tick(2);
    out_ready = 1'b0;
    drive_word(4'b0001, 1'b0);
    req = 1'b1;
    wait_sig("mid_valid", 1'b0, 1'b1, 10);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'd0);
    check("mid_rst_count", 32'(rx_count), 32'd0);
    @(negedge rclk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    tick(8);
    check("held_req_no_capture", 32'(out_valid), 32'd0);
    check("held_req_count", 32'(rx_count), 32'd0);
    req = 1'b0;
    tick(4);
    check("held_req_still_none", 32'(rx_count), 32'd0);
    do_word("rearm", 4'b0001, 1'b0);
    tick(4);
    check("rearm_count", 32'(rx_count), 32'd1);

    // Randomized run: exactly 256 words from a fresh reset, so rx_count wraps to 0
    do_reset();
    delivered = 0;
    exp_cnt = 0;
    fork
      begin : sender
        logic [WIDTH-1:0] w;
        for (int k = 0; k < 256; k++) begin
          tick($urandom_range(0, 3));
          w = WIDTH'($urandom);
          drive_word(w, 1'b0);
          req = 1'b1;
          sb_q.push_back(w);
          wait_sig("rnd_ack1", 1'b1, 1'b1, 500);
          tick($urandom_range(0, 3));
          req = 1'b0;
          wait_sig("rnd_ack0", 1'b1, 1'b0, 50);
        end
      end
      begin : consumer
        bit               fire = 1'b0;
        logic [WIDTH-1:0] seen = '0;
        int               cyc = 0;
        while (delivered < 256 && cyc < 20000) begin
          @(negedge rclk);
          cyc++;
          if (fire) begin
            delivered++;
            exp_cnt = (exp_cnt + 1) % 256;
            if (sb_q.size() == 0) check("rnd_spurious", 32'(seen), 32'hFFFF_FFFF);
            else check("rnd_data", 32'(seen), 32'(sb_q.pop_front()));
            check("rnd_count", 32'(rx_count), 32'(exp_cnt));
            check("rnd_ack_after_accept", 32'(ack), 32'd1);
          end
          out_ready = 1'($urandom_range(0, 1));
          fire = out_valid && out_ready;
          seen = data_out;
        end
        if (delivered < 256) check("rnd_timeout", 32'(delivered), 32'd256);
      end
    join
    out_ready = 1'b1;
    tick(4);
    check("wrap_count", 32'(rx_count), 32'd0);
    check("wrap_delivered", 32'(delivered), 32'd256);
    check("wrap_leftover", 32'(sb_q.size()), 32'd0);
    check("wrap_valid", 32'(out_valid), 32'd0);

`ifdef HS_RX_PARITY_EN
    // Sticky parity error; the bad word is still delivered
    do_reset();
    check("par_rst", 32'(par_err), 32'd0);
    do_word("par_bad", 4'b1001, 1'b1);
    check("par_set", 32'(par_err), 32'd1);
    do_word("par_good1", 4'b0110, 1'b0);
    do_word("par_good2", 4'b1110, 1'b0);
    check("par_sticky", 32'(par_err), 32'd1);
    check("par_count", 32'(rx_count), 32'd3);
    do_reset();
    check("par_clear", 32'(par_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
